// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC, memory req/ack handshake, 2-entry prefetch FIFO.
// Define IF_BRANCH_EN to enable branch redirect and in-flight drop handling.
module if_fetch_unit #(
  parameter int              ADDR_W   = 32,
  parameter int              DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  output logic              rom_req_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic              rom_ack_i,
  input  logic [DATA_W-1:0] rom_data_i,
  output logic [ADDR_W-1:0] if_pc,
  output logic [DATA_W-1:0] if_inst,
  output logic              if_valid
);

  typedef enum logic {
    IDLE,
    REQ
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] pc_next;
  logic [ADDR_W-1:0] fifo_pc [2];
  logic [DATA_W-1:0] fifo_inst [2];
  logic              rd_ptr;
  logic              wr_ptr;
  logic [1:0]        count;
  logic [1:0]        count_next;
  logic              ack;
  logic              push;
  logic              pop;
  logic              slot_free;
  logic              branch;
  logic              drop;
  logic              unused_stall;

  assign unused_stall = ^stall[5:1];

`ifdef IF_BRANCH_EN
  logic drop_q;

  assign branch = branch_flag_i;
  assign drop   = drop_q;

  // Outstanding request must finish on the bus; its data is discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_q <= 1'b0;
    end else if (ack) begin
      drop_q <= 1'b0;
    end else if (branch && state == REQ) begin
      drop_q <= 1'b1;
    end
  end
`else
  logic unused_branch;

  assign branch        = 1'b0;
  assign drop          = 1'b0;
  assign unused_branch = ^{branch_flag_i, branch_target_i};
`endif

  assign ack  = rom_req_o & rom_ack_i;
  assign push = ack & ~drop & ~branch;
  assign pop  = ~stall[0] & (count != 2'd0) & ~branch;

  always_comb begin
    count_next = count + {1'b0, push} - {1'b0, pop};
    if (branch) begin
      count_next = 2'd0;
    end
  end

  assign slot_free = (count_next != 2'd2);

  always_comb begin
    pc_next = fetch_pc;
    if (push) begin
      pc_next = fetch_pc + ADDR_W'(4);
    end
`ifdef IF_BRANCH_EN
    if (branch) begin
      pc_next = branch_target_i;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]   <= rom_addr_o;
      fifo_inst[wr_ptr] <= rom_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rom_req_o  <= 1'b0;
      rom_addr_o <= '0;
      fetch_pc   <= RESET_PC;
      count      <= 2'd0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
    end else begin
      fetch_pc <= pc_next;
      count    <= count_next;
      if (branch) begin
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
      end else begin
        if (push) wr_ptr <= ~wr_ptr;
        if (pop)  rd_ptr <= ~rd_ptr;
      end
      unique case (state)
        IDLE: begin
          if (slot_free) begin
            state      <= REQ;
            rom_req_o  <= 1'b1;
            rom_addr_o <= pc_next;
          end
        end
        REQ: begin
          // Address only moves once the current transfer completes.
          if (ack) begin
            if (slot_free) begin
              rom_addr_o <= pc_next;
            end else begin
              state     <= IDLE;
              rom_req_o <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  assign if_valid = (count != 2'd0);
  assign if_pc    = if_valid ? fifo_pc[rd_ptr]   : '0;
  assign if_inst  = if_valid ? fifo_inst[rd_ptr] : '0;

endmodule
